// File: rtl/pixel_sequencer_pkg.sv
// pixel_sequencer_pkg
// Shared definitions for the pixel sequencer: FSM state type, default
// beat counts per output pixel (5x5 read window, 3x3 write footprint)
// and the pixel-count width.
package pixel_sequencer_pkg;

    localparam int READS_PER_PIXEL_DEF  = 25;
    localparam int WRITES_PER_PIXEL_DEF = 9;
    localparam int PIX_W                = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        FINISH  = 3'd5
    } state_e;

endpackage

// File: rtl/pixel_sequencer_if.sv
// pixel_sequencer_if
// Handshake between the sequencer and the address counter.
//   o_inc_raddr / o_inc_waddr : one-cycle increment pulses (sequencer -> counter)
//   i_r_ready   / i_w_ready   : counter has finished the previous increment
// Signal names are seen from the sequencer side.
interface pixel_sequencer_if;
    logic o_inc_raddr;
    logic o_inc_waddr;
    logic i_r_ready;
    logic i_w_ready;

    modport master (output o_inc_raddr, output o_inc_waddr,
                    input  i_r_ready,   input  i_w_ready);
    modport slave  (input  o_inc_raddr, input  o_inc_waddr,
                    output i_r_ready,   output i_w_ready);
endinterface

// File: rtl/pixel_sequencer_beat_counter.sv
// beat_counter
// Counts beats 0..MAX-1 within one pixel and wraps to 0 when advanced on
// the terminal count.
//   clk, n_rst : clock, async active-low reset
//   i_clr      : synchronous clear (priority over i_en)
//   i_en       : advance one beat
//   o_cnt      : current beat index
//   o_tc       : high while o_cnt == MAX-1
module beat_counter #(
    parameter int MAX = 25,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    assign o_tc  = (r_cnt == W'(MAX - 1));
    assign o_cnt = r_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)      r_cnt <= '0;
        else if (i_clr)  r_cnt <= '0;
        else if (i_en)   r_cnt <= o_tc ? '0 : r_cnt + W'(1);
    end

endmodule

// File: rtl/pixel_sequencer.sv
// pixel_sequencer
// Drives the address counter through READS_PER_PIXEL read increments then
// WRITES_PER_PIXEL write increments per output pixel, for i_num_pixels
// pixels per frame.
//   clk, n_rst     : clock, async active-low reset
//   i_start        : start pulse (ignored while busy)
//   i_num_pixels   : pixels in the frame, sampled on accepted start
//   addr_if        : increment pulses out / ready in (master side)
//   o_read_idx     : current read beat within the pixel
//   o_write_idx    : current write beat within the pixel
//   o_pixel_cnt    : pixels completed in this frame
//   o_busy, o_done : status, done is a one-cycle end-of-frame pulse
module pixel_sequencer
    import pixel_sequencer_pkg::*;
#(
    parameter int READS_PER_PIXEL  = READS_PER_PIXEL_DEF,
    parameter int WRITES_PER_PIXEL = WRITES_PER_PIXEL_DEF
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_start,
    input  logic [PIX_W-1:0]      i_num_pixels,
    pixel_sequencer_if.master     addr_if,
    output logic [4:0]            o_read_idx,
    output logic [3:0]            o_write_idx,
    output logic [PIX_W-1:0]      o_pixel_cnt,
    output logic                  o_busy,
    output logic                  o_done
);

    state_e           r_state, w_next;
    logic             r_first;        // first cycle of a WAIT state
    logic [PIX_W-1:0] r_num;
    logic [PIX_W-1:0] r_pixel_cnt;
    logic             r_inc_raddr, r_inc_waddr, r_busy, r_done;
    logic             w_inc_raddr, w_inc_waddr, w_busy, w_done;
    logic             w_accept, w_rd_acc, w_wr_acc, w_rd_tc, w_wr_tc, w_more;

    assign w_accept = (r_state == IDLE) && i_start;
    // The counter's ready still reflects the previous increment during the
    // first WAIT cycle, so it is only trusted from the second cycle on.
    assign w_rd_acc = (r_state == RD_WAIT) && !r_first && addr_if.i_r_ready;
    assign w_wr_acc = (r_state == WR_WAIT) && !r_first && addr_if.i_w_ready;
    // r_pixel_cnt < r_num throughout a frame, so +1 cannot overflow.
    assign w_more   = (r_pixel_cnt + PIX_W'(1)) < r_num;

    beat_counter #(.MAX(READS_PER_PIXEL), .W(5)) u_rd_beat (
        .clk(clk), .n_rst(n_rst), .i_clr(w_accept), .i_en(w_rd_acc),
        .o_cnt(o_read_idx), .o_tc(w_rd_tc)
    );

    beat_counter #(.MAX(WRITES_PER_PIXEL), .W(4)) u_wr_beat (
        .clk(clk), .n_rst(n_rst), .i_clr(w_accept), .i_en(w_wr_acc),
        .o_cnt(o_write_idx), .o_tc(w_wr_tc)
    );

    // State register; outputs are registered from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_first     <= 1'b0;
            r_inc_raddr <= 1'b0;
            r_inc_waddr <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_first     <= (r_state == RD_REQ) || (r_state == WR_REQ);
            r_inc_raddr <= w_inc_raddr;
            r_inc_waddr <= w_inc_waddr;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = (i_num_pixels != '0) ? RD_REQ : FINISH;
            RD_REQ:  w_next = RD_WAIT;
            RD_WAIT: if (w_rd_acc) w_next = w_rd_tc ? WR_REQ : RD_REQ;
            WR_REQ:  w_next = WR_WAIT;
            WR_WAIT: if (w_wr_acc) w_next = !w_wr_tc ? WR_REQ : (w_more ? RD_REQ : FINISH);
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_inc_raddr = (w_next == RD_REQ);
        w_inc_waddr = (w_next == WR_REQ);
        w_busy      = (w_next != IDLE);
        w_done      = (w_next == FINISH);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_num       <= '0;
            r_pixel_cnt <= '0;
        end else if (w_accept) begin
            r_num       <= i_num_pixels;
            r_pixel_cnt <= '0;
        end else if (w_wr_acc && w_wr_tc) begin
            r_pixel_cnt <= r_pixel_cnt + PIX_W'(1);
        end
    end

    assign addr_if.o_inc_raddr = r_inc_raddr;
    assign addr_if.o_inc_waddr = r_inc_waddr;
    assign o_pixel_cnt         = r_pixel_cnt;
    assign o_busy              = r_busy;
    assign o_done              = r_done;

endmodule

// File: tb/tb_pixel_sequencer.sv
// tb_pixel_sequencer
// Directed bench for pixel_sequencer with a behavioural address counter
// that raises ready two cycles after each increment pulse.
module tb_pixel_sequencer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_num_pixels = '0;
    logic [4:0]  o_read_idx;
    logic [3:0]  o_write_idx;
    logic [31:0] o_pixel_cnt;
    logic        o_busy, o_done;

    int total = 0;
    int bad   = 0;

    pixel_sequencer_if ac ();

    pixel_sequencer dut (
        .clk(clk), .n_rst(n_rst), .i_start(i_start), .i_num_pixels(i_num_pixels),
        .addr_if(ac), .o_read_idx(o_read_idx), .o_write_idx(o_write_idx),
        .o_pixel_cnt(o_pixel_cnt), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // Behavioural address counter plus pulse bookkeeping
    int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, both_cnt = 0;
    int          rtmr = 0, wtmr = 0;
    logic [31:0] raddr = 32'd1, waddr = 32'd200001;
    logic        r_rdy = 1'b1, w_rdy = 1'b1;
    logic        stall = 1'b0;

    assign ac.i_r_ready = r_rdy & ~stall;
    assign ac.i_w_ready = w_rdy;

    always @(posedge clk) begin
        if (ac.o_inc_raddr) begin
            rd_cnt <= rd_cnt + 1; raddr <= raddr + 1; r_rdy <= 1'b0; rtmr <= 2;
        end else if (rtmr > 1) rtmr <= rtmr - 1;
        else if (rtmr == 1) begin r_rdy <= 1'b1; rtmr <= 0; end
        if (ac.o_inc_waddr) begin
            wr_cnt <= wr_cnt + 1; waddr <= waddr + 1; w_rdy <= 1'b0; wtmr <= 2;
        end else if (wtmr > 1) wtmr <= wtmr - 1;
        else if (wtmr == 1) begin w_rdy <= 1'b1; wtmr <= 0; end
        if (o_done) done_cnt <= done_cnt + 1;
        if (ac.o_inc_raddr && ac.o_inc_waddr) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] n);
        @(negedge clk);
        i_num_pixels = n;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int b = done_cnt;
        int n = 0;
        while (done_cnt == b && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done_cnt != b, 1);
    endtask

    int b_rd, b_wr, b_done, b_raddr, b_waddr, s_rd, s_wr, n;

    initial begin
        // Reset and idle
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_inc_raddr", ac.o_inc_raddr, 0);
        chk("rst_inc_waddr", ac.o_inc_waddr, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_read_idx", o_read_idx, 0);
        chk("rst_write_idx", o_write_idx, 0);
        chk("rst_pixel_cnt", o_pixel_cnt, 0);

        // Single pixel: all 25 reads precede the first write
        b_rd = rd_cnt; b_wr = wr_cnt; b_done = done_cnt;
        pulse_start(1);
        chk("p1_busy", o_busy, 1);
        n = 0;
        while (wr_cnt == b_wr && n < 2000) begin @(negedge clk); n++; end
        chk("p1_reads_before_write", rd_cnt - b_rd, 25);
        wait_done("p1_done_seen", 2000);
        chk("p1_reads", rd_cnt - b_rd, 25);
        chk("p1_writes", wr_cnt - b_wr, 9);
        chk("p1_pixel_cnt", o_pixel_cnt, 1);
        repeat (3) @(negedge clk);
        chk("p1_done_pulses", done_cnt - b_done, 1);
        chk("p1_idle", o_busy, 0);

        // Zero-pixel frame: done the cycle after start, no increments
        b_rd = rd_cnt; b_wr = wr_cnt;
        @(negedge clk);
        i_num_pixels = 0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("p0_done", o_done, 1);
        chk("p0_busy", o_busy, 1);
        @(negedge clk);
        chk("p0_done_low", o_done, 0);
        chk("p0_busy_low", o_busy, 0);
        chk("p0_no_inc", (rd_cnt - b_rd) + (wr_cnt - b_wr), 0);

        // Larger frame against the address model
        b_rd = rd_cnt; b_wr = wr_cnt; b_raddr = raddr; b_waddr = waddr;
        pulse_start(30);
        wait_done("p30_done_seen", 20000);
        chk("p30_reads", rd_cnt - b_rd, 750);
        chk("p30_writes", wr_cnt - b_wr, 270);
        chk("p30_raddr", raddr, b_raddr + 750);
        chk("p30_waddr", waddr, b_waddr + 270);
        chk("p30_pixel_cnt", o_pixel_cnt, 30);

        // Read-ready stall mid-pixel with a start while busy
        b_rd = rd_cnt; b_wr = wr_cnt; b_done = done_cnt;
        pulse_start(2);
        n = 0;
        while (rd_cnt - b_rd < 10 && n < 1000) begin @(negedge clk); n++; end
        chk("st_reached", rd_cnt - b_rd, 10);
        stall = 1'b1;
        s_rd = rd_cnt; s_wr = wr_cnt;
        repeat (20) @(negedge clk);
        i_num_pixels = 7;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (29) @(negedge clk);
        chk("st_no_rd", rd_cnt, s_rd);
        chk("st_no_wr", wr_cnt, s_wr);
        chk("st_busy", o_busy, 1);
        chk("st_read_idx", o_read_idx, 9);
        stall = 1'b0;
        wait_done("st_done_seen", 2000);
        chk("st_reads", rd_cnt - b_rd, 50);
        chk("st_writes", wr_cnt - b_wr, 18);
        chk("st_pixel_cnt", o_pixel_cnt, 2);
        repeat (5) @(negedge clk);
        chk("st_one_done", done_cnt - b_done, 1);
        chk("st_idle", o_busy, 0);

        // Reset during WR_WAIT of the third pixel
        b_wr = wr_cnt; b_done = done_cnt;
        pulse_start(5);
        n = 0;
        while (wr_cnt - b_wr < 19 && n < 2000) begin @(negedge clk); n++; end
        chk("rs_reached", wr_cnt - b_wr, 19);
        chk("rs_pix_before", o_pixel_cnt, 2);
        n_rst = 1'b0;
        #1;
        chk("rs_busy", o_busy, 0);
        chk("rs_inc_r", ac.o_inc_raddr, 0);
        chk("rs_inc_w", ac.o_inc_waddr, 0);
        chk("rs_done", o_done, 0);
        chk("rs_pixel_cnt", o_pixel_cnt, 0);
        chk("rs_write_idx", o_write_idx, 0);
        chk("rs_read_idx", o_read_idx, 0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rs_stay_idle", o_busy, 0);
        chk("rs_no_done", done_cnt - b_done, 0);
        b_rd = rd_cnt; b_wr = wr_cnt;
        pulse_start(2);
        wait_done("rs2_done_seen", 2000);
        chk("rs2_reads", rd_cnt - b_rd, 50);
        chk("rs2_writes", wr_cnt - b_wr, 18);
        chk("rs2_pixel_cnt", o_pixel_cnt, 2);

        chk("never_both_inc", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
